chess_clock_referee: RTL and testbench



---
 rtl/chess_clock_pkg.sv | 22 ++
 rtl/chess_clock_preset.sv | 45 ++++
 rtl/chess_clock_referee.sv | 182 ++++++++++++++++++
 tb/tb_chess_clock_referee.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/chess_clock_pkg.sv
// chess_clock_pkg: shared types and constants for the chess clock referee.
//   - chess_state_e : game FSM state encoding (also driven out on o_state)
//   - PresetIdxW    : width of the time-preset index
//   - PresetTable   : 2-digit BCD start values, {tens, ones}
package chess_clock_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StRunA  = 3'd1,
    StRunB  = 3'd2,
    StOver  = 3'd3,
    StPause = 3'd4
  } chess_state_e;

  localparam int unsigned PresetIdxW = 3;

  // Entries 5..7 are never selected with the default table size; they repeat 05 as a safe value.
  localparam logic [7:0] PresetTable [0:7] = '{
    8'h05, 8'h10, 8'h30, 8'h60, 8'h99, 8'h05, 8'h05, 8'h05
  };

endpackage

// File: rtl/chess_clock_preset.sv
// chess_clock_preset: time-preset selector.
// Holds the preset index, steps it with wrap-around and looks up the BCD start value.
// Ports:
//   i_clk, i_rst   clock, asynchronous active-low reset
//   i_step         advance to next preset this cycle
//   o_changed      strobe, high in the cycle a step is accepted
//   o_init         BCD start value, [1]=tens, [0]=ones (combinational from index)
module chess_clock_preset
  import chess_clock_pkg::*;
#(
  parameter int unsigned p_preset_count   = 5,
  parameter int unsigned p_default_preset = 0
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_step,
  output logic            o_changed,
  output logic [1:0][3:0] o_init
);

  localparam logic [PresetIdxW-1:0] LastIdx  = PresetIdxW'(p_preset_count - 1);
  localparam logic [PresetIdxW-1:0] ResetIdx = PresetIdxW'(p_default_preset);

  logic [PresetIdxW-1:0] r_idx;
  logic [PresetIdxW-1:0] w_idx_next;

  always_comb begin
    w_idx_next = r_idx;
    if (i_step) begin
      w_idx_next = (r_idx == LastIdx) ? '0 : r_idx + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_idx <= ResetIdx;
    end else begin
      r_idx <= w_idx_next;
    end
  end

  assign o_changed = i_step;
  assign o_init    = PresetTable[r_idx];

endmodule

// File: rtl/chess_clock_referee.sv
// chess_clock_referee: game controller for a two-player chess clock.
// Optional pause support is enabled by defining CHESS_CLOCK_REFEREE_PAUSE_EN.
// Ports:
//   i_clk, i_rst        clock, asynchronous active-low reset
//   i_new               abandon game and reload times (highest priority)
//   i_preset            step to next time preset (IDLE only)
//   i_pause             pause/resume (only with CHESS_CLOCK_REFEREE_PAUSE_EN)
//   i_turn_a/b          player click: that player ends its own move
//   i_zero_a/b          player counter reached 00
//   o_restart           one-cycle pulse: counters reload o_init
//   o_init              BCD start value, [1]=tens, [0]=ones
//   o_stop_a/b          1 = freeze that player's clock
//   o_win_a/b           winner flags, held until i_new or reset
//   o_state             current FSM state
module chess_clock_referee
  import chess_clock_pkg::*;
#(
  parameter int unsigned p_preset_count   = 5,
  parameter int unsigned p_default_preset = 0
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_new,
  input  logic            i_preset,
  input  logic            i_pause,
  input  logic            i_turn_a,
  input  logic            i_turn_b,
  input  logic            i_zero_a,
  input  logic            i_zero_b,
  output logic            o_restart,
  output logic [1:0][3:0] o_init,
  output logic            o_stop_a,
  output logic            o_stop_b,
  output logic            o_win_a,
  output logic            o_win_b,
  output logic [2:0]      o_state
);

  chess_state_e r_state, w_state_d;
  logic r_win_a, r_win_b, w_win_a_d, w_win_b_d;
  logic r_stop_a, r_stop_b, w_stop_a_d, w_stop_b_d;
  logic r_restart, w_restart_d;
  logic r_started;
  logic w_preset_step, w_preset_changed;

`ifdef CHESS_CLOCK_REFEREE_PAUSE_EN
  // Side to move when paused: 0 = A, 1 = B.
  logic r_side, w_side_d;
`else
  logic w_unused_pause;
  assign w_unused_pause = i_pause;
`endif

  // Presets only move while idle, and a simultaneous i_new wins.
  assign w_preset_step = i_preset & ~i_new & (r_state == StIdle);

  chess_clock_preset #(
    .p_preset_count  (p_preset_count),
    .p_default_preset(p_default_preset)
  ) u_preset (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_step   (w_preset_step),
    .o_changed(w_preset_changed),
    .o_init   (o_init)
  );

  // State register (and registered outputs).
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state   <= StIdle;
      r_win_a   <= 1'b0;
      r_win_b   <= 1'b0;
      r_stop_a  <= 1'b1;
      r_stop_b  <= 1'b1;
      r_restart <= 1'b0;
      r_started <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_win_a   <= w_win_a_d;
      r_win_b   <= w_win_b_d;
      r_stop_a  <= w_stop_a_d;
      r_stop_b  <= w_stop_b_d;
      r_restart <= w_restart_d;
      r_started <= 1'b1;
    end
  end

`ifdef CHESS_CLOCK_REFEREE_PAUSE_EN
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_side <= 1'b0;
    end else begin
      r_side <= w_side_d;
    end
  end
`endif

  // Next-state logic.
  always_comb begin
    w_state_d = r_state;
    w_win_a_d = r_win_a;
    w_win_b_d = r_win_b;
`ifdef CHESS_CLOCK_REFEREE_PAUSE_EN
    w_side_d  = r_side;
`endif
    if (i_new) begin
      w_state_d = StIdle;
      w_win_a_d = 1'b0;
      w_win_b_d = 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          // Simultaneous clicks are ambiguous and ignored.
          if (i_turn_a && !i_turn_b) begin
            w_state_d = StRunB;
          end else if (i_turn_b && !i_turn_a) begin
            w_state_d = StRunA;
          end
        end
        StRunA: begin
          // Flag fall beats a late click in the same cycle.
          if (i_zero_a) begin
            w_state_d = StOver;
            w_win_b_d = 1'b1;
          end else if (i_turn_a) begin
            w_state_d = StRunB;
`ifdef CHESS_CLOCK_REFEREE_PAUSE_EN
          end else if (i_pause) begin
            w_state_d = StPause;
            w_side_d  = 1'b0;
`endif
          end
        end
        StRunB: begin
          if (i_zero_b) begin
            w_state_d = StOver;
            w_win_a_d = 1'b1;
          end else if (i_turn_b) begin
            w_state_d = StRunA;
`ifdef CHESS_CLOCK_REFEREE_PAUSE_EN
          end else if (i_pause) begin
            w_state_d = StPause;
            w_side_d  = 1'b1;
`endif
          end
        end
        StOver: begin
          w_state_d = StOver;
        end
`ifdef CHESS_CLOCK_REFEREE_PAUSE_EN
        StPause: begin
          if (i_pause) begin
            w_state_d = r_side ? StRunB : StRunA;
          end
        end
`endif
        default: begin
          w_state_d = StIdle;
          w_win_a_d = 1'b0;
          w_win_b_d = 1'b0;
        end
      endcase
    end
  end

  // Output logic: registered outputs follow the next state.
  always_comb begin
    w_stop_a_d  = (w_state_d != StRunA);
    w_stop_b_d  = (w_state_d != StRunB);
    // ~r_started gives the single load pulse right after reset release.
    w_restart_d = i_new | w_preset_changed | ~r_started;
  end

  assign o_state   = r_state;
  assign o_win_a   = r_win_a;
  assign o_win_b   = r_win_b;
  assign o_stop_a  = r_stop_a;
  assign o_stop_b  = r_stop_b;
  assign o_restart = r_restart;

endmodule

// File: tb/tb_chess_clock_referee.sv
module tb_chess_clock_referee;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            i_new = 1'b0, i_preset = 1'b0, i_pause = 1'b0;
  logic            i_turn_a = 1'b0, i_turn_b = 1'b0, i_zero_a = 1'b0, i_zero_b = 1'b0;
  logic            o_restart, o_stop_a, o_stop_b, o_win_a, o_win_b;
  logic [1:0][3:0] o_init;
  logic [2:0]      o_state;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  chess_clock_referee #(
    .p_preset_count  (5),
    .p_default_preset(0)
  ) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_new    (i_new),
    .i_preset (i_preset),
    .i_pause  (i_pause),
    .i_turn_a (i_turn_a),
    .i_turn_b (i_turn_b),
    .i_zero_a (i_zero_a),
    .i_zero_b (i_zero_b),
    .o_restart(o_restart),
    .o_init   (o_init),
    .o_stop_a (o_stop_a),
    .o_stop_b (o_stop_b),
    .o_win_a  (o_win_a),
    .o_win_b  (o_win_b),
    .o_state  (o_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs applied before this are seen at that edge, then cleared.
  task automatic tick();
    @(posedge clk);
    #1;
    i_new = 0; i_preset = 0; i_pause = 0;
    i_turn_a = 0; i_turn_b = 0; i_zero_a = 0; i_zero_b = 0;
  endtask

  task automatic chk_game(input string tag, input logic [2:0] st, input logic sa, input logic sb,
                          input logic wa, input logic wb);
    chk({tag, ".state"},  32'(o_state),  32'(st));
    chk({tag, ".stop_a"}, 32'(o_stop_a), 32'(sa));
    chk({tag, ".stop_b"}, 32'(o_stop_b), 32'(sb));
    chk({tag, ".win_a"},  32'(o_win_a),  32'(wa));
    chk({tag, ".win_b"},  32'(o_win_b),  32'(wb));
  endtask

  task automatic press_preset(input string tag, input logic [7:0] exp_init);
    i_preset = 1;
    tick();
    chk({tag, ".init"},    32'(o_init),    32'(exp_init));
    chk({tag, ".restart"}, 32'(o_restart), 32'd1);
    tick();
    chk({tag, ".restart_end"}, 32'(o_restart), 32'd0);
  endtask

  initial begin
    // Reset held
    @(posedge clk); #1;
    chk_game("rst", 3'd0, 1, 1, 0, 0);
    chk("rst.restart", 32'(o_restart), 32'd0);
    chk("rst.init",    32'(o_init),    32'h05);

    // Release: one restart pulse
    rst = 1;
    tick();
    chk("boot.restart", 32'(o_restart), 32'd1);
    chk("boot.init",    32'(o_init),    32'h05);
    tick();
    chk("boot.restart_end", 32'(o_restart), 32'd0);
    chk_game("boot", 3'd0, 1, 1, 0, 0);

    // Preset stepping with wrap
    press_preset("pre1", 8'h10);
    press_preset("pre2", 8'h30);
    press_preset("pre3", 8'h60);
    press_preset("pre4", 8'h99);
    press_preset("pre5", 8'h05);
    press_preset("pre6", 8'h10);

    // Start game: B clicks -> A to move
    i_turn_b = 1; tick();
    chk_game("start", 3'd1, 0, 1, 0, 0);
    // Preset ignored while running
    i_preset = 1; tick();
    chk("run.preset_init",    32'(o_init),    32'h10);
    chk("run.preset_restart", 32'(o_restart), 32'd0);
    // B click in RUN_A ignored, zero_b ignored
    i_turn_b = 1; i_zero_b = 1; tick();
    chk_game("runa_ign", 3'd1, 0, 1, 0, 0);
    i_turn_a = 1; tick();
    chk_game("to_runb", 3'd2, 1, 0, 0, 0);
    i_turn_a = 1; tick();
    chk_game("runb_ign", 3'd2, 1, 0, 0, 0);

    // Pause
    i_pause = 1; tick();
`ifdef CHESS_CLOCK_REFEREE_PAUSE_EN
    chk_game("pause", 3'd4, 1, 1, 0, 0);
    i_zero_b = 1; i_turn_b = 1; tick();
    chk_game("pause_ign", 3'd4, 1, 1, 0, 0);
`else
    chk_game("pause_off", 3'd2, 1, 0, 0, 0);
`endif
    i_pause = 1; tick();
    chk_game("resume", 3'd2, 1, 0, 0, 0);

    // Back to RUN_A, then flag fall together with click
    i_turn_b = 1; tick();
    chk_game("to_runa", 3'd1, 0, 1, 0, 0);
    i_zero_a = 1; i_turn_a = 1; tick();
    chk_game("over_b", 3'd3, 1, 1, 0, 1);
    i_turn_a = 1; i_turn_b = 1; i_zero_b = 1; i_zero_a = 1; i_preset = 1; i_pause = 1; tick();
    chk_game("over_ign", 3'd3, 1, 1, 0, 1);
    chk("over.init", 32'(o_init), 32'h10);

    // New game
    i_new = 1; tick();
    chk_game("new", 3'd0, 1, 1, 0, 0);
    chk("new.restart", 32'(o_restart), 32'd1);
    chk("new.init",    32'(o_init),    32'h10);
    tick();
    chk("new.restart_end", 32'(o_restart), 32'd0);

    // Simultaneous clicks in IDLE
    i_turn_a = 1; i_turn_b = 1; tick();
    chk_game("idle_both", 3'd0, 1, 1, 0, 0);

    // A wins on B flag fall
    i_turn_a = 1; tick();
    chk_game("runb2", 3'd2, 1, 0, 0, 0);
    i_zero_b = 1; i_zero_a = 1; tick();
    chk_game("over_a", 3'd3, 1, 1, 1, 0);

    // i_new beats preset and click in the same cycle
    i_new = 1; tick();
    i_new = 1; i_preset = 1; i_turn_a = 1; tick();
    chk_game("new_prio", 3'd0, 1, 1, 0, 0);
    chk("new_prio.init",    32'(o_init),    32'h10);
    chk("new_prio.restart", 32'(o_restart), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
